fp_add_arbiter: RTL and testbench

- Round-robin arbiter that shares one pipelined FP32 adder (fixed latency, no stall input) between NUM_REQ requesters.
- Issues at most one operation per cycle and carries a requester tag down a shadow pipeline matched to the adder latency.
- Steers each result, with its 2-bit number status, back to the requester that issued it.
- Sits between the requester clients and the adder; the adder's own reset is driven externally.

---
 rtl/fp_add_arbiter.sv | 142 ++++++++++++++
 tb/tb_fp_add_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP32 adder between NUM_REQ requesters.
// A tag pipeline matched to the adder latency routes each result back to the requester that issued it.
module fp_add_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_vld_i,
  output logic [NUM_REQ-1:0]    req_rdy_o,
  input  logic [NUM_REQ*32-1:0] req_a_i,
  input  logic [NUM_REQ*32-1:0] req_b_i,
  output logic                  add_vld_o,
  output logic [31:0]           add_a_o,
  output logic [31:0]           add_b_o,
  input  logic [31:0]           add_res_i,
  input  logic [1:0]            add_status_i,
  output logic [NUM_REQ-1:0]    rsp_vld_o,
  output logic [31:0]           rsp_res_o,
  output logic [1:0]            rsp_status_o,
  output logic                  busy_o
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTST);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]   NUM_C   = (IDW + 1)'(NUM_REQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]     ptr_q;
  tag_t [LATENCY-1:0] tag_q;
  tag_t               tag_out;
  logic [CW-1:0]      outst_q [NUM_REQ];
  logic [31:0]        last_a_q, last_b_q;

  logic               grant, issue;
  logic [IDW-1:0]     win_id;
  logic [IDW:0]       cand;
  logic [NUM_REQ-1:0] elig, inc, dec;

  assign tag_out = tag_q[LATENCY-1];

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    elig = '0;
    inc  = '0;
    dec  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = req_vld_i[k] && (outst_q[k] < MAX_CNT);
      inc[k]  = req_rdy_o[k];
      dec[k]  = tag_out.vld && (tag_out.id == IDW'(k));
    end
  end

  // First eligible requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW + 1)'(i);
      if (cand >= NUM_C) cand = cand - NUM_C;
      if (!grant && elig[cand[IDW-1:0]]) begin
        grant  = 1'b1;
        win_id = cand[IDW-1:0];
      end
    end
  end

  // The grant is purely combinational, so it is masked while reset is held to keep every output low.
  assign issue = grant & rst_i;

  always_comb begin
    req_rdy_o = '0;
    if (issue) req_rdy_o[win_id] = 1'b1;
  end

  assign add_vld_o = issue;
  assign add_a_o   = issue ? req_a_i[32*int'(win_id) +: 32] : last_a_q;
  assign add_b_o   = issue ? req_b_i[32*int'(win_id) +: 32] : last_b_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q        <= '0;
      tag_q        <= '0;
      last_a_q     <= '0;
      last_b_q     <= '0;
      rsp_vld_o    <= '0;
      rsp_res_o    <= '0;
      rsp_status_o <= '0;
      for (int k = 0; k < NUM_REQ; k++) outst_q[k] <= '0;
    end else begin
      if (issue) begin
        ptr_q    <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
        last_a_q <= add_a_o;
        last_b_q <= add_b_o;
      end

      tag_q[0] <= {issue, win_id};
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];

      rsp_vld_o <= '0;
      if (tag_out.vld) begin
        rsp_vld_o[tag_out.id] <= 1'b1;
        rsp_res_o             <= add_res_i;
        rsp_status_o          <= add_status_i;
      end

      // A grant and a retirement for the same requester in one cycle cancel out.
      for (int k = 0; k < NUM_REQ; k++) begin
        if (inc[k] && !dec[k])      outst_q[k] <= outst_q[k] + 1'b1;
        else if (dec[k] && !inc[k]) outst_q[k] <= outst_q[k] - 1'b1;
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < LATENCY; i++) busy_o = busy_o | tag_q[i].vld;
    for (int k = 0; k < NUM_REQ; k++) busy_o = busy_o | (outst_q[k] != '0);
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        assert (outst_q[k] <= MAX_CNT);
        assert (!(inc[k] && !dec[k] && outst_q[k] == MAX_CNT));
        assert (!(dec[k] && !inc[k] && outst_q[k] == '0));
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: a stub FP adder, a queue-based reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_fp_add_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int LATENCY   = 4;
  localparam int MAX_OUTST = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b0;
  logic [NUM_REQ-1:0]    req_vld_i = '0;
  logic [NUM_REQ-1:0]    req_rdy_o;
  logic [NUM_REQ*32-1:0] req_a_i = '0;
  logic [NUM_REQ*32-1:0] req_b_i = '0;
  logic                  add_vld_o;
  logic [31:0]           add_a_o, add_b_o;
  logic [31:0]           add_res_i;
  logic [1:0]            add_status_i;
  logic [NUM_REQ-1:0]    rsp_vld_o;
  logic [31:0]           rsp_res_o;
  logic [1:0]            rsp_status_o;
  logic                  busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  fp_add_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .add_vld_o(add_vld_o), .add_a_o(add_a_o), .add_b_o(add_b_o),
    .add_res_i(add_res_i), .add_status_i(add_status_i),
    .rsp_vld_o(rsp_vld_o), .rsp_res_o(rsp_res_o), .rsp_status_o(rsp_status_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Float helpers; exact for the integer-valued and small fractional operands used here.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [1:0] fp_status(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = fp_add(a, b);
    return {s[30:0] == 31'd0, s[31]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return r2f(real'(int'($urandom_range(0, 1000)) - 500));
  endfunction

  function automatic logic [NUM_REQ*32-1:0] rand_bits();
    logic [NUM_REQ*32-1:0] v;
    for (int k = 0; k < NUM_REQ; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NUM_REQ*32-1:0] rand_fps();
    logic [NUM_REQ*32-1:0] v;
    for (int k = 0; k < NUM_REQ; k++) v[32*k +: 32] = rand_fp();
    return v;
  endfunction

  // Stub adder: fixed latency, never reset, drives noise when no operation was issued.
  logic [33:0] apipe [LATENCY];
  initial for (int i = 0; i < LATENCY; i++) apipe[i] = '0;
  always @(posedge clk_i) begin
    apipe[0] <= add_vld_o ? {fp_status(add_a_o, add_b_o), fp_add(add_a_o, add_b_o)}
                          : {2'($urandom), 32'($urandom)};
    for (int i = 1; i < LATENCY; i++) apipe[i] <= apipe[i-1];
  end
  assign add_res_i    = apipe[LATENCY-1][31:0];
  assign add_status_i = apipe[LATENCY-1][33:32];

  // Reference model: list of accepted operations, each due back LATENCY+1 cycles after its handshake.
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    longint      due;
  } op_t;

  op_t         pend[$];
  int          ptr_m = 0;
  logic [31:0] last_a = '0, last_b = '0, last_res = '0;
  logic [1:0]  last_stat = '0;
  longint      cyc = 0;

  always @(negedge clk_i) begin
    int                 cnt [NUM_REQ];
    int                 win, k;
    logic [NUM_REQ-1:0] e_rdy, e_rsp;
    logic [31:0]        ea, eb;
    logic               e_busy;
    if (!rst_i) begin
      pend.delete();
      ptr_m = 0; last_a = '0; last_b = '0; last_res = '0; last_stat = '0;
      check("rst_rdy", req_rdy_o, 0);
      check("rst_add_vld", add_vld_o, 0);
      check("rst_add_a", add_a_o, 0);
      check("rst_add_b", add_b_o, 0);
      check("rst_rsp_vld", rsp_vld_o, 0);
      check("rst_rsp_res", rsp_res_o, 0);
      check("rst_rsp_status", rsp_status_o, 0);
      check("rst_busy", busy_o, 0);
    end else begin
      e_busy = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) cnt[j] = 0;
      foreach (pend[i]) if (pend[i].due > cyc) begin cnt[pend[i].id]++; e_busy = 1'b1; end
      win = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        k = (ptr_m + i) % NUM_REQ;
        if (win < 0 && req_vld_i[k] && cnt[k] < MAX_OUTST) win = k;
      end
      e_rdy = '0;
      if (win >= 0) e_rdy[win] = 1'b1;
      ea = (win >= 0) ? req_a_i[32*win +: 32] : last_a;
      eb = (win >= 0) ? req_b_i[32*win +: 32] : last_b;
      e_rsp = '0;
      foreach (pend[i]) if (pend[i].due == cyc) begin
        e_rsp[pend[i].id] = 1'b1;
        last_res  = fp_add(pend[i].a, pend[i].b);
        last_stat = fp_status(pend[i].a, pend[i].b);
      end
      check("m_rdy", req_rdy_o, e_rdy);
      check("m_add_vld", add_vld_o, win >= 0);
      check("m_add_a", add_a_o, ea);
      check("m_add_b", add_b_o, eb);
      check("m_rsp_vld", rsp_vld_o, e_rsp);
      check("m_rsp_res", rsp_res_o, last_res);
      check("m_rsp_status", rsp_status_o, last_stat);
      check("m_busy", busy_o, e_busy);
      if (win >= 0) begin
        pend.push_back('{id: win, a: ea, b: eb, due: cyc + LATENCY + 1});
        last_a = ea; last_b = eb;
        ptr_m = (win + 1) % NUM_REQ;
      end
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    end
    cyc++;
  end

  // Directed helpers: each enters and leaves 1 time unit after a rising edge.
  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      req_vld_i = NUM_REQ'($urandom);
      req_a_i   = rand_bits();
      req_b_i   = rand_bits();
      @(negedge clk_i);
      check("reset_outputs", {req_rdy_o, add_vld_o, rsp_vld_o, busy_o}, 0);
      advance();
    end
    req_vld_i = '0;
    req_a_i   = rand_fps();
    req_b_i   = rand_fps();
    rst_i     = 1'b1;
  endtask

  task automatic drain();
    req_vld_i = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (!busy_o) break;
      advance();
    end
    check("drain_idle", busy_o, 0);
    advance();
  endtask

  localparam logic [31:0] FAIR_SUM [NUM_REQ] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    advance();

    // Reset with noisy inputs, then the first grant goes to requester 0.
    do_reset(4);
    req_vld_i = '1;
    @(negedge clk_i);
    check("rel_first_grant", req_rdy_o, 4'b0001);
    check("rel_add_vld", add_vld_o, 1);
    advance();
    drain();

    // Single operation from requester 2: 1.0 + 2.0 = 3.0 after LATENCY+1 cycles.
    req_vld_i = 4'b0100;
    req_a_i   = rand_fps();
    req_b_i   = rand_fps();
    req_a_i[64 +: 32] = 32'h3F800000;
    req_b_i[64 +: 32] = 32'h40000000;
    @(negedge clk_i);
    check("single_rdy", req_rdy_o, 4'b0100);
    check("single_add_a", add_a_o, 32'h3F800000);
    check("single_add_b", add_b_o, 32'h40000000);
    for (int j = 1; j <= 6; j++) begin
      advance();
      req_vld_i = '0;
      @(negedge clk_i);
      check("single_rdy_once", req_rdy_o, 0);
      check("single_rsp_vld", rsp_vld_o, (j == 5) ? 4'b0100 : 4'b0000);
      if (j == 5) check("single_rsp_res", rsp_res_o, 32'h40400000);
    end
    advance();
    drain();

    // Fairness: all requesters valid for 12 cycles, requester k adds (1.0+k)+1.0.
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      req_vld_i = (i < 12) ? '1 : '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        req_a_i[32*k +: 32] = r2f(real'(1 + k));
        req_b_i[32*k +: 32] = 32'h3F800000;
      end
      @(negedge clk_i);
      if (i < 12) check("fair_grant", req_rdy_o, 64'(1) << (i % 4));
      check("fair_rsp_vld", rsp_vld_o, (i >= 5 && i < 17) ? 64'(1) << ((i - 5) % 4) : 64'(0));
      if (i >= 5 && i < 17) check("fair_rsp_res", rsp_res_o, FAIR_SUM[(i - 5) % 4]);
      advance();
    end
    drain();

    // Outstanding cap: requester 1 alone gets two grants per LATENCY+1 window.
    for (int i = 0; i < 17; i++) begin
      req_vld_i = 4'b0010;
      req_a_i   = rand_fps();
      req_b_i   = rand_fps();
      @(negedge clk_i);
      check("cap_grant", req_rdy_o, (i % 5 == 0 || i % 5 == 1) ? 4'b0010 : 4'b0000);
      advance();
    end
    drain();

    // Grant and retirement for requester 0 in the same cycle leave its count unchanged.
    for (int i = 0; i < 7; i++) begin
      req_vld_i = (i == 0 || i >= 4) ? 4'b0001 : 4'b0000;
      req_a_i   = rand_fps();
      req_b_i   = rand_fps();
      if (i == 0) begin
        req_a_i[31:0] = 32'h3FC00000;
        req_b_i[31:0] = 32'h40200000;
      end
      @(negedge clk_i);
      check("sim_grant", req_rdy_o, (i == 0 || i == 4 || i == 5) ? 4'b0001 : 4'b0000);
      if (i == 5) begin
        check("sim_rsp_vld", rsp_vld_o, 4'b0001);
        check("sim_rsp_res", rsp_res_o, 32'h40800000);
      end
      advance();
    end
    drain();

    // Mid-flight reset: three ops issued, reset two cycles later, nothing comes back.
    for (int i = 0; i < 4; i++) begin
      req_vld_i = (i < 3) ? '1 : '0;
      req_a_i   = rand_fps();
      req_b_i   = rand_fps();
      @(negedge clk_i);
      advance();
    end
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("mid_no_rsp", rsp_vld_o, 0);
      check("mid_busy", busy_o, 0);
      advance();
    end
    req_vld_i = '1;
    @(negedge clk_i);
    check("mid_ptr_zero", req_rdy_o, 4'b0001);
    advance();
    drain();

    // Randomized traffic with varying load and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      int dens;
      dens = (c < 700) ? 80 : (c < 1400) ? 30 : 55;
      if ($urandom_range(0, 249) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        for (int k = 0; k < NUM_REQ; k++) req_vld_i[k] = ($urandom_range(0, 99) < dens);
        req_a_i = rand_fps();
        req_b_i = rand_fps();
        @(negedge clk_i);
        advance();
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
